mem_port_arbiter: RTL

- Shares the single memory port of the mp1 core family between two requesters: instruction side (i_*) and data side (d_*).
- Sits between the core's fetch/load-store paths (or future I/D caches) and the one physical memory interface driven by the bench.
- Grants one requester at a time and holds the grant until that access completes.
- Never issues a simultaneous read and write downstream.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction (i_*) and
// data (d_*) requesters of an mp1 core. One side is granted at a time and the
// grant is held until the downstream mem_resp pulse.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   i_read/i_write/i_address/
//   i_wdata/i_byte_enable         instruction-side request
//   i_resp, i_rdata               instruction-side completion and read data
//   d_*                           data-side request/response, same shape as i_*
//   mem_read/mem_write/
//   mem_address/mem_wdata/
//   mem_byte_enable               downstream request, driven from the granted side
//   mem_resp, mem_rdata           downstream completion and read data
//   busy                          a grant is held
//   err                           sticky: a requester asserted read and write together
//
// Request/response paths are combinational from the granted requester so that
// a grant adds no extra cycle once it is registered; with no grant they are 0.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_read,
    input  logic                    i_write,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_byte_enable,
    output logic                    i_resp,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
    output logic                    d_resp,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic                    mem_resp,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0 = I served last, 1 = D served last
    logic   err_q, err_d;

    logic i_req, d_req, i_both, d_both;

    assign i_req  = i_read | i_write;
    assign d_req  = d_read | d_write;
    assign i_both = i_read & i_write;
    assign d_both = d_read & d_write;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    // Next-state, arbitration and port steering
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        err_d           = err_q;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        i_resp          = 1'b0;
        i_rdata         = '0;
        d_resp          = 1'b0;
        d_rdata         = '0;

        unique case (state_q)
            IDLE: begin
                if (i_both || d_both) begin
                    err_d = 1'b1;
                end
                // mem_resp arriving here has no owner and is dropped
                if (i_req && d_req) begin
                    if (ARB_MODE == 0) begin
                        state_d = GRANT_D;
                    end else begin
                        state_d = last_grant_q ? GRANT_I : GRANT_D;
                    end
                end else if (d_req) begin
                    state_d = GRANT_D;
                end else if (i_req) begin
                    state_d = GRANT_I;
                end
            end

            GRANT_I: begin
                // a write wins over a simultaneous read
                mem_read        = i_read & ~i_write;
                mem_write       = i_write;
                mem_address     = i_address;
                mem_wdata       = i_wdata;
                mem_byte_enable = i_byte_enable;
                i_resp          = mem_resp;
                i_rdata         = mem_rdata;
                if (i_both) begin
                    err_d = 1'b1;
                end
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end

            GRANT_D: begin
                mem_read        = d_read & ~d_write;
                mem_write       = d_write;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                mem_byte_enable = d_byte_enable;
                d_resp          = mem_resp;
                d_rdata         = mem_rdata;
                if (d_both) begin
                    err_d = 1'b1;
                end
                if (mem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign err  = err_q;

endmodule
